axi_lite_id_slave: RTL and testbench
====================================

AXI_LITE_ID_SLAVE -- requirements
Module: axi_lite_id_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, byte address width.
REQ-003 SHALL have parameter CORE_ID, default 32'hA5E1_0001, value returned at CORE_ID_ADDR.
REQ-004 SHALL have parameter DATE, default 32'h2024_0101, value returned at DATE_ADDR.
REQ-005 SHALL have port s_axi_aclk, input, 1, the single clock.
REQ-006 SHALL have port s_axi_aresetn, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port s_axi_awaddr, input, ADDR_WIDTH, write address.
REQ-008 SHALL have port s_axi_awvalid, input, 1, write address valid.
REQ-009 SHALL have port s_axi_awready, output, 1, write address ready.
REQ-010 SHALL have port s_axi_wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port s_axi_wstrb, input, DATA_WIDTH/8, byte enables.
REQ-012 SHALL have port s_axi_wvalid, input, 1, write data valid.
REQ-013 SHALL have port s_axi_wready, output, 1, write data ready.
REQ-014 SHALL have port s_axi_bresp, output, 2, write response.
REQ-015 SHALL have port s_axi_bvalid, output, 1, write response valid.
REQ-016 SHALL have port s_axi_bready, input, 1, write response ready.
REQ-017 SHALL have port s_axi_araddr, input, ADDR_WIDTH, read address.
REQ-018 SHALL have port s_axi_arvalid, input, 1, read address valid.
REQ-019 SHALL have port s_axi_arready, output, 1, read address ready.
REQ-020 SHALL have port s_axi_rdata, output, DATA_WIDTH, read data.
REQ-021 SHALL have port s_axi_rresp, output, 2, read response.
REQ-022 SHALL have port s_axi_rvalid, output, 1, read data valid.
REQ-023 SHALL have port s_axi_rready, input, 1, read data ready.

Function
REQ-024 SHALL implement the following register map, decoded on addr[6:2] with addr[1:0] ignored:
- 0x00 CORE_ID: read-only.
- 0x04 DATE: read-only.
- 0x08 SCRATCH: read/write.
- 0x0C WR_COUNT: read-only; counts completed OKAY writes and wraps from 0xFFFF_FFFF to 0.
REQ-025 The write FSM SHALL have two states, W_IDLE and W_RESP.
- In W_IDLE, awready and wready SHALL be 1 until their own handshake completes; each then drops independently, so AW and W may arrive in either order or in the same cycle.
REQ-026 When both AW and W are captured, on the next edge the FSM SHALL:
- apply the write with per-byte wstrb to SCRATCH (an all-zero wstrb changes nothing but still returns OKAY);
- increment WR_COUNT;
- assert bvalid and enter W_RESP.
REQ-027 In W_RESP, bvalid and bresp SHALL be held stable until bready=1. On that edge bvalid SHALL drop, the FSM SHALL return to W_IDLE, and awready/wready SHALL reassert on the same edge.
REQ-028 bresp SHALL be OKAY (2'b00) for SCRATCH.
- It SHALL be SLVERR (2'b10) for writes to CORE_ID, DATE, WR_COUNT or unmapped addresses.
- A SLVERR write SHALL change no state and SHALL NOT increment WR_COUNT.
REQ-029 The read FSM SHALL have two states, R_IDLE and R_DATA.
- In R_IDLE, arready=1.
- On an arvalid&&arready edge, the FSM SHALL latch rdata/rresp, set rvalid=1, clear arready and enter R_DATA.
REQ-030 In R_DATA, rdata, rresp and rvalid SHALL be held until rready=1; on that edge rvalid SHALL drop and arready SHALL reassert.
REQ-031 Reads of mapped addresses SHALL return OKAY; unmapped reads SHALL return rdata=0 with rresp=SLVERR.
REQ-032 The read and write FSMs SHALL be independent. If a SCRATCH write commits on the same edge that an AR is accepted for SCRATCH, the read SHALL return the pre-write value.

Reset
REQ-033 While s_axi_aresetn=0, all outputs SHALL be 0, SCRATCH=0, WR_COUNT=0, and both FSMs SHALL be idle; awready, wready and arready SHALL rise on the first clock edge after release.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no partial register update and no response issued.

Structure
REQ-035 SCRATCH_ADDR (7'h08), WR_COUNT_ADDR (7'h0C) and RESP_OKAY/RESP_SLVERR constants SHALL be added to axi_example_defn_pkg next to CORE_ID_ADDR and DATE_ADDR.
REQ-036 The FSM state enum typedefs SHALL live in axi_example_defn_pkg.
REQ-037 The block SHALL be a single module with no sub-modules.

Verification
REQ-038 Read 0x00 then 0x04 after reset -> rdata 32'hA5E1_0001 then 32'h2024_0101, both rresp OKAY.
REQ-039 Write 0x08 data 32'hDEAD_BEEF wstrb 4'b0101, with W arriving 3 cycles before AW; then read 0x08 -> rdata 32'h00AD_00EF, bresp OKAY, and read 0x0C -> 1.
REQ-040 Write 0x00 data 32'h1234_5678 -> bresp SLVERR; a following read of 0x00 returns 32'hA5E1_0001 and WR_COUNT is unchanged.
REQ-041 Read 0x40 -> rdata 0, rresp SLVERR; bready held 0 for 5 cycles during a write -> bvalid and bresp held stable, awready stays 0.
REQ-042 Drive s_axi_aresetn low while in W_RESP after a SCRATCH write -> outputs 0 immediately, SCRATCH reads 0 after release, arready is 1 one edge after release.

Source files
------------

// File: rtl/axi_example_defn_pkg.sv
// Shared register map, response codes and FSM state types for the AXI-Lite ID slave.
// The register map is decoded on address bits [6:2], so the *_IDX values are word indices.
package axi_example_defn_pkg;

    localparam logic [6:0] CORE_ID_ADDR  = 7'h00;
    localparam logic [6:0] DATE_ADDR     = 7'h04;
    localparam logic [6:0] SCRATCH_ADDR  = 7'h08;
    localparam logic [6:0] WR_COUNT_ADDR = 7'h0C;

    localparam logic [4:0] CORE_ID_IDX  = CORE_ID_ADDR[6:2];
    localparam logic [4:0] DATE_IDX     = DATE_ADDR[6:2];
    localparam logic [4:0] SCRATCH_IDX  = SCRATCH_ADDR[6:2];
    localparam logic [4:0] WR_COUNT_IDX = WR_COUNT_ADDR[6:2];

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Byte-lane merge: each set strobe bit replaces that byte of the old word.
    function automatic logic [31:0] strobe_merge(input logic [31:0] old_word,
                                                 input logic [31:0] new_word,
                                                 input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_id_slave.sv
// AXI4-Lite slave exposing CORE_ID, DATE, a scratch register and a write counter.
// Read and write channels run as independent two-state FSMs; all outputs are registered.
module axi_lite_id_slave
    import axi_example_defn_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 7,
    parameter logic [31:0] CORE_ID    = 32'hA5E1_0001,
    parameter logic [31:0] DATE       = 32'h2024_0101
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    w_state_t                  w_state_r, w_state_s;
    logic                      aw_have_r, aw_have_s;
    logic                      w_have_r, w_have_s;
    logic [4:0]                awidx_r, awidx_s;
    logic [DATA_WIDTH-1:0]     wdata_r, wdata_s;
    logic [DATA_WIDTH/8-1:0]   wstrb_r, wstrb_s;
    logic                      awready_r, awready_s;
    logic                      wready_r, wready_s;
    logic                      bvalid_r, bvalid_s;
    logic [1:0]                bresp_r, bresp_s;
    logic [DATA_WIDTH-1:0]     scratch_r, scratch_s;
    logic [DATA_WIDTH-1:0]     wr_count_r, wr_count_s;

    r_state_t                  r_state_r, r_state_s;
    logic                      arready_r, arready_s;
    logic                      rvalid_r, rvalid_s;
    logic [DATA_WIDTH-1:0]     rdata_r, rdata_s;
    logic [1:0]                rresp_r, rresp_s;
    logic [DATA_WIDTH-1:0]     rd_value_s;
    logic [1:0]                rd_resp_s;

    logic                      unused_s;
    assign unused_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // State and output registers for both channels.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_r  <= W_IDLE;
            aw_have_r  <= 1'b0;
            w_have_r   <= 1'b0;
            awidx_r    <= 5'd0;
            wdata_r    <= {DATA_WIDTH{1'b0}};
            wstrb_r    <= {(DATA_WIDTH/8){1'b0}};
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= 2'b00;
            scratch_r  <= {DATA_WIDTH{1'b0}};
            wr_count_r <= {DATA_WIDTH{1'b0}};
            r_state_r  <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= {DATA_WIDTH{1'b0}};
            rresp_r    <= 2'b00;
        end else begin
            w_state_r  <= w_state_s;
            aw_have_r  <= aw_have_s;
            w_have_r   <= w_have_s;
            awidx_r    <= awidx_s;
            wdata_r    <= wdata_s;
            wstrb_r    <= wstrb_s;
            awready_r  <= awready_s;
            wready_r   <= wready_s;
            bvalid_r   <= bvalid_s;
            bresp_r    <= bresp_s;
            scratch_r  <= scratch_s;
            wr_count_r <= wr_count_s;
            r_state_r  <= r_state_s;
            arready_r  <= arready_s;
            rvalid_r   <= rvalid_s;
            rdata_r    <= rdata_s;
            rresp_r    <= rresp_s;
        end
    end

    // Write FSM: capture AW and W independently, commit once both are held.
    always_comb begin
        w_state_s  = w_state_r;
        aw_have_s  = aw_have_r;
        w_have_s   = w_have_r;
        awidx_s    = awidx_r;
        wdata_s    = wdata_r;
        wstrb_s    = wstrb_r;
        awready_s  = awready_r;
        wready_s   = wready_r;
        bvalid_s   = bvalid_r;
        bresp_s    = bresp_r;
        scratch_s  = scratch_r;
        wr_count_s = wr_count_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_have_r && w_have_r) begin
                    if (awidx_r == SCRATCH_IDX) begin
                        scratch_s  = strobe_merge(scratch_r, wdata_r, wstrb_r);
                        wr_count_s = wr_count_r + 32'd1;
                        bresp_s    = RESP_OKAY;
                    end else begin
                        bresp_s    = RESP_SLVERR;
                    end
                    bvalid_s  = 1'b1;
                    aw_have_s = 1'b0;
                    w_have_s  = 1'b0;
                    awready_s = 1'b0;
                    wready_s  = 1'b0;
                    w_state_s = W_RESP;
                end else begin
                    if (s_axi_awvalid && awready_r) begin
                        aw_have_s = 1'b1;
                        awidx_s   = s_axi_awaddr[6:2];
                    end else begin
                        aw_have_s = aw_have_r;
                    end
                    if (s_axi_wvalid && wready_r) begin
                        w_have_s = 1'b1;
                        wdata_s  = s_axi_wdata;
                        wstrb_s  = s_axi_wstrb;
                    end else begin
                        w_have_s = w_have_r;
                    end
                    awready_s = ~aw_have_s;
                    wready_s  = ~w_have_s;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_s  = 1'b0;
                    awready_s = 1'b1;
                    wready_s  = 1'b1;
                    w_state_s = W_IDLE;
                end else begin
                    bvalid_s  = 1'b1;
                end
            end
            default: begin
                w_state_s = W_IDLE;
                aw_have_s = 1'b0;
                w_have_s  = 1'b0;
                bvalid_s  = 1'b0;
                awready_s = 1'b1;
                wready_s  = 1'b1;
            end
        endcase
    end

    // Read decode of the register map; unmapped words return zero with SLVERR.
    always_comb begin
        rd_value_s = {DATA_WIDTH{1'b0}};
        rd_resp_s  = RESP_OKAY;
        case (s_axi_araddr[6:2])
            CORE_ID_IDX:  rd_value_s = CORE_ID;
            DATE_IDX:     rd_value_s = DATE;
            SCRATCH_IDX:  rd_value_s = scratch_r;
            WR_COUNT_IDX: rd_value_s = wr_count_r;
            default: begin
                rd_value_s = {DATA_WIDTH{1'b0}};
                rd_resp_s  = RESP_SLVERR;
            end
        endcase
    end

    // Read FSM: scratch_r is sampled pre-commit, so a same-edge write is not visible.
    always_comb begin
        r_state_s = r_state_r;
        arready_s = arready_r;
        rvalid_s  = rvalid_r;
        rdata_s   = rdata_r;
        rresp_s   = rresp_r;
        case (r_state_r)
            R_IDLE: begin
                if (s_axi_arvalid && arready_r) begin
                    rdata_s   = rd_value_s;
                    rresp_s   = rd_resp_s;
                    rvalid_s  = 1'b1;
                    arready_s = 1'b0;
                    r_state_s = R_DATA;
                end else begin
                    arready_s = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_s  = 1'b0;
                    arready_s = 1'b1;
                    r_state_s = R_IDLE;
                end else begin
                    arready_s = 1'b0;
                end
            end
            default: begin
                rvalid_s  = 1'b0;
                arready_s = 1'b1;
                r_state_s = R_IDLE;
            end
        endcase
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;

endmodule

// File: tb/tb_axi_lite_id_slave.sv
// Randomized scoreboard bench for axi_lite_id_slave: stimulus pushes expected responses,
// a negedge monitor pops and compares them when a B or R handshake is presented.
module tb_axi_lite_id_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  awaddr = 7'h00;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [6:0]  araddr = 7'h00;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    axi_lite_id_slave dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [1:0]  bq[$];
    rexp_t       rq[$];
    logic [31:0] m_scratch = 32'h0;
    logic [31:0] m_count = 32'h0;
    logic [1:0]  mon_b;
    rexp_t       mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: writes only land at word 2 (SCRATCH); everything else is refused.
    function automatic logic [1:0] model_write(input logic [6:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        if (a[6:2] == 5'd2) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
            end
            m_count = m_count + 32'd1;
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic rexp_t model_read(input logic [6:0] a);
        rexp_t e;
        e.resp = 2'b00;
        case (a[6:2])
            5'd0:    e.data = 32'hA5E1_0001;
            5'd1:    e.data = 32'h2024_0101;
            5'd2:    e.data = m_scratch;
            5'd3:    e.data = m_count;
            default: begin e.data = 32'h0; e.resp = 2'b10; end
        endcase
        return e;
    endfunction

    // Monitor: one comparison per presented B or R handshake.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            check("b_expected", 64'(bq.size() > 0), 64'd1);
            if (bq.size() > 0) begin
                mon_b = bq.pop_front();
                check("bresp", 64'(bresp), 64'(mon_b));
            end
        end
        if (rst_n && rvalid && rready) begin
            check("r_expected", 64'(rq.size() > 0), 64'd1);
            if (rq.size() > 0) begin
                mon_r = rq.pop_front();
                check("rdata", 64'(rdata), 64'(mon_r.data));
                check("rresp", 64'(rresp), 64'(mon_r.resp));
            end
        end
    end

    // lead > 0: W issued that many cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int hold, input bit abandon);
        logic [1:0] e;
        bit aw_done, w_done, aw_acc, w_acc;
        int t_aw, t_w, cyc, wt;
        e = model_write(a, d, s);
        bq.push_back(e);
        t_w  = (lead > 0) ? 0 : -lead;
        t_aw = (lead > 0) ? lead : 0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc = 0;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (!aw_done && cyc >= t_aw) awvalid = 1'b1;
            if (!w_done && cyc >= t_w) wvalid = 1'b1;
            @(negedge clk);
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            @(posedge clk);
            #1;
            if (aw_acc) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_acc) begin w_done = 1'b1; wvalid = 1'b0; end
            cyc++;
        end
        check("wr_handshake", 64'(aw_done && w_done), 64'd1);
        wt = 0;
        @(negedge clk);
        while (!bvalid && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        check("bvalid_seen", 64'(bvalid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bvalid_hold", 64'(bvalid), 64'd1);
            check("bresp_hold", 64'(bresp), 64'(e));
            check("awready_low", 64'(awready), 64'd0);
        end
        if (!abandon) begin
            @(posedge clk);
            #1 bready = 1'b1;
            @(posedge clk);
            #1 bready = 1'b0;
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int delay);
        int cyc;
        rq.push_back(model_read(a));
        araddr  = a;
        arvalid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!arready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("arready_seen", 64'(arready), 64'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!rvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rvalid_seen", 64'(rvalid), 64'd1);
        repeat (delay) @(posedge clk);
        @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    function automatic logic [6:0] rand_addr();
        if ($urandom_range(0, 3) != 0) begin
            return 7'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
        end
        return 7'($urandom);
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("awready_after_reset", 64'(awready), 64'd1);
        check("wready_after_reset", 64'(wready), 64'd1);
        check("arready_after_reset", 64'(arready), 64'd1);

        do_read(7'h00, 0);
        do_read(7'h04, 0);
        do_write(7'h08, 32'hDEAD_BEEF, 4'b0101, 3, 0, 1'b0);
        do_read(7'h08, 0);
        do_read(7'h0C, 0);
        do_write(7'h00, 32'h1234_5678, 4'b1111, 0, 0, 1'b0);
        do_read(7'h00, 0);
        do_read(7'h0C, 0);
        do_read(7'h40, 0);
        do_write(7'h09, 32'hCAFE_F00D, 4'b1111, -2, 5, 1'b0);
        do_write(7'h0B, 32'h1111_1111, 4'b0000, 1, 0, 1'b0);
        do_read(7'h0A, 1);
        do_read(7'h0D, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(rand_addr(), $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                         int'($urandom_range(0, 2)), 1'b0);
            end else begin
                do_read(rand_addr(), int'($urandom_range(0, 2)));
            end
        end

        do_write(7'h08, 32'h5A5A_A5A5, 4'b1111, 0, 1, 1'b1);
        bq.delete();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midresp_reset_outputs",
              64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}), 64'd0);
        m_scratch = 32'h0;
        m_count   = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arready_after_release", 64'(arready), 64'd1);
        do_read(7'h08, 0);
        do_read(7'h0C, 0);

        repeat (5) @(posedge clk);
        check("b_queue_drained", 64'(bq.size()), 64'd0);
        check("r_queue_drained", 64'(rq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
